// File: rtl/backward_recursion_pkg.sv
// Shared types for the forward/backward complex recursion blocks.
// Holds the reader FSM encoding and the bank count of the ping-pong buffer.
package backward_recursion_pkg;

   localparam int NUM_BANKS = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } rd_state_t;

endpackage

// File: rtl/backward_recursion_cfx_mac.sv
// Complex multiply-shift-saturate-add: y = sat(((s*f) >>> (DW-1)) + x), per part.
// Shared with the forward recursion; purely combinational.
module cfx_mac #(
   parameter int DW = 16
) (
   input  logic signed [DW-1:0] s_r,
   input  logic signed [DW-1:0] s_i,
   input  logic signed [DW-1:0] f_r,
   input  logic signed [DW-1:0] f_i,
   input  logic signed [DW-1:0] x_r,
   input  logic signed [DW-1:0] x_i,
   output logic signed [DW-1:0] y_r,
   output logic signed [DW-1:0] y_i
);

   localparam int PW  = 2 * DW;
   localparam int ACW = PW + 1;
   localparam int SW  = DW + 3;

   logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
   logic signed [ACW-1:0] acc_r, acc_i, sh_r, sh_i;
   logic signed [SW-1:0]  sum_r, sum_i;

   // Clamp when the guard bits above the DW-bit result disagree with the sign.
   function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
      if (v[SW-1:DW-1] == {(SW-DW+1){v[SW-1]}})
         sat = v[DW-1:0];
      else
         sat = v[SW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   endfunction

   assign p_rr  = PW'(s_r) * PW'(f_r);
   assign p_ii  = PW'(s_i) * PW'(f_i);
   assign p_ri  = PW'(s_r) * PW'(f_i);
   assign p_ir  = PW'(s_i) * PW'(f_r);

   assign acc_r = ACW'(p_rr) - ACW'(p_ii);
   assign acc_i = ACW'(p_ri) + ACW'(p_ir);

   // Arithmetic shift floors toward -inf; the result keeps DW+2 significant bits.
   assign sh_r  = acc_r >>> (DW - 1);
   assign sh_i  = acc_i >>> (DW - 1);

   assign sum_r = SW'(sh_r) + SW'(x_r);
   assign sum_i = SW'(sh_i) + SW'(x_i);

   assign y_r   = sat(sum_r);
   assign y_i   = sat(sum_i);

endmodule

// File: rtl/backward_recursion.sv
// Batch-reversing complex recursion: samples fill a ping-pong buffer, each full
// bank is replayed DEPTH-1..0 through s = sat(((s*F) >>> (DW-1)) + x).
module backward_recursion
   import backward_recursion_pkg::*;
#(
   parameter int DEPTH    = 8,
   parameter int DW       = 16,
   parameter int FACTOR_R = 0,
   parameter int FACTOR_I = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_r,
   input  logic signed [DW-1:0] in_i,
   input  logic signed [DW-1:0] init_r,
   input  logic signed [DW-1:0] init_i,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_r,
   output logic signed [DW-1:0] out_i,
   output logic                 out_last
);

   localparam int AW = $clog2(DEPTH);
   localparam logic signed [DW-1:0] F_R = DW'(FACTOR_R);
   localparam logic signed [DW-1:0] F_I = DW'(FACTOR_I);
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef struct packed {
      logic signed [DW-1:0] r;
      logic signed [DW-1:0] i;
   } cfx_t;

   cfx_t mem [NUM_BANKS*DEPTH];

   rd_state_t      state, state_nxt;
   logic           wr_bank, rd_bank;
   logic [AW-1:0]  wr_idx, rd_idx;
   logic [1:0]     full, full_nxt;
   cfx_t           s_q, x_q, y;
   logic           accept, wr_done, fire, release_bank;

   assign in_ready     = !full[wr_bank];
   assign accept       = in_valid && in_ready;
   assign wr_done      = accept && (wr_idx == LAST_IDX);
   assign out_valid    = (state == RUN);
   assign out_last     = out_valid && (rd_idx == '0);
   assign fire         = out_valid && out_ready;
   assign release_bank = fire && (rd_idx == '0);

   // Release and completion always target different banks, so both may apply.
   always_comb begin
      full_nxt = full;
      if (release_bank) full_nxt[rd_bank] = 1'b0;
      if (wr_done)      full_nxt[wr_bank] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (full_nxt[rd_bank]) state_nxt = PRIME;
         PRIME:   state_nxt = RUN;
         RUN:     if (release_bank) state_nxt = full_nxt[~rd_bank] ? PRIME : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) mem[{wr_bank, wr_idx}] <= '{r: in_r, i: in_i};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         full    <= '0;
         wr_bank <= 1'b0;
         wr_idx  <= '0;
         rd_bank <= 1'b0;
         rd_idx  <= '0;
         s_q     <= '0;
         x_q     <= '0;
      end else begin
         state <= state_nxt;
         full  <= full_nxt;
         if (accept) begin
            wr_idx <= wr_done ? '0 : wr_idx + 1'b1;
            if (wr_done) wr_bank <= ~wr_bank;
         end
         if (state == PRIME) begin
            s_q    <= '{r: init_r, i: init_i};
            x_q    <= mem[{rd_bank, LAST_IDX}];
            rd_idx <= LAST_IDX;
         end else if (fire) begin
            s_q <= y;
            if (release_bank) begin
               rd_bank <= ~rd_bank;
            end else begin
               // Prefetch the next sample so a new state is ready every cycle.
               x_q    <= mem[{rd_bank, rd_idx - 1'b1}];
               rd_idx <= rd_idx - 1'b1;
            end
         end
      end
   end

   // The output is the state updated by the current sample; it only moves on a handshake.
   cfx_mac #(.DW(DW)) u_mac (
      .s_r(s_q.r), .s_i(s_q.i),
      .f_r(F_R),   .f_i(F_I),
      .x_r(x_q.r), .x_i(x_q.i),
      .y_r(y.r),   .y_i(y.i)
   );

   assign out_r = y.r;
   assign out_i = y.i;

endmodule

// File: doc/backward_recursion.md
BACKWARD_RECURSION -- requirements
Module: backward_recursion

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning batch length in samples (power of 2, ≥4).
REQ-002 SHALL have parameter DW, default 16, meaning signed data width per real/imag part.
REQ-003 SHALL have parameters FACTOR_R and FACTOR_I, default 0, meaning the recursion factor as signed Q1.(DW-1) integers.
REQ-004 SHALL have port clk, input, 1, the clock.
REQ-005 SHALL have port rst, input, 1, reset: synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1, meaning the input sample is valid.
REQ-007 SHALL have port in_ready, output, 1, meaning a sample is accepted on in_valid&&in_ready.
REQ-008 SHALL have ports in_r and in_i, input, DW each, meaning the input sample.
REQ-009 SHALL have ports init_r and init_i, input, DW each, meaning the recursion start state, sampled at batch start.
REQ-010 SHALL have port out_valid, output, 1, meaning output valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the output is consumed on out_valid&&out_ready.
REQ-012 SHALL have ports out_r and out_i, output, DW each, meaning the recursion state.
REQ-013 SHALL have port out_last, output, 1, meaning final output of a batch.

Function
REQ-014 SHALL store accepted samples into a ping-pong buffer of 2 banks × DEPTH complex entries; the write index runs 0..DEPTH-1, then switches bank.
REQ-015 SHALL hand a full bank to the reader; the reader processes it in reverse index order DEPTH-1..0.
REQ-016 SHALL load state from init at reader batch start, then per sample: s = sat(trunc((s·F) >>> (DW-1)) + x[k]).
REQ-017 SHALL use a full complex product (4 products, each 2·DW bits) and an arithmetic shift (truncation toward −inf).
REQ-018 SHALL saturate the add result to [−2^(DW-1), 2^(DW-1)−1] separately per part.
REQ-019 SHALL make out_r/out_i equal to the updated state s; each out_valid beat carries one state, DEPTH beats per batch.
REQ-020 SHALL assert out_last on the beat for index 0.
REQ-021 SHALL use a reader FSM: IDLE (no full bank) -> PRIME (synchronous buffer read of index DEPTH-1) -> RUN (one state update per output handshake) -> IDLE or PRIME (if the other bank is full) after the out_last handshake.
REQ-022 SHALL assert the first out_valid exactly 2 cycles after the accepting cycle of a batch's last sample when the reader is IDLE.
REQ-023 SHALL allow sustained throughput of one output per cycle while out_ready is held high.
REQ-024 SHALL hold out_valid, out_r, out_i and out_last stable while out_valid && !out_ready; the recursion SHALL NOT advance.
REQ-025 SHALL deassert in_ready only when the write bank is still owned by the reader (both banks full).
REQ-026 SHALL, when the writer completes a bank on the same cycle the reader releases one, swap with no lost cycle and no stall.
REQ-027 SHALL ignore inputs while in_ready=0; no sample is lost or duplicated.

Reset
REQ-028 SHALL, on rst=0 at a clk edge, set out_valid=0, out_last=0, out_r=out_i=0, in_ready=1, FSM=IDLE, write index=0, both banks empty.
REQ-029 SHALL discard partially written or partially read batches on reset mid-operation; buffer contents need no clearing.

Structure
REQ-030 SHALL place the complex fixed-point typedef (DW-parameterised r/i struct) and the FSM state enum in the shared Util package.
REQ-031 SHALL implement the multiply-shift-saturate-add as one sub-module, cfx_mac, also reusable by the forward recursion.

Verification (DEPTH=4, DW=16, F=(16384,0), i.e. 0.5, init=0)
REQ-032 SHALL cover: in_r=1000,2000,3000,4000 (in_i=0), out_ready=1 -> out_r=4000,5000,4500,3250; out_last on 3250; first out_valid 2 cycles after the 4000 is accepted.
REQ-033 SHALL cover: in_r=32767 ×4 -> out_r=32767,32767,32767,32767 (saturation); F=(0,32767) with a single in=(16384,0) then zeros gives the imag part rotating per REQ-016 with truncation.
REQ-034 SHALL cover: out_ready low for 3 cycles mid-batch -> the held beat is unchanged, and the remaining sequence is identical to the unstalled case.
REQ-035 SHALL cover: 12 samples streamed back-to-back with out_ready=0 -> in_ready drops after sample 8; on out_ready=1 all 12 outputs arrive in correct batch-reversed order.
REQ-036 SHALL cover: rst=0 asserted during the 3rd output beat -> out_valid=0 next cycle, in_ready=1, and a fresh batch afterwards produces the REQ-032 values.
REQ-037 SHALL cover: init=(100,−100) with inputs all 0 -> out=(50,−50),(25,−25),(12,−13),(6,−7).
